// File: rtl/word_serializer.sv
// word_serializer: parallel-in, serial-out reader for registered words.
// A W-bit word is accepted over a valid/ready handshake and then presented
// one bit per enabled trigger edge on sout, qualified by sout_valid.
//
// Ports:
//   trigger     clock; all state changes on its rising edge
//   reset       synchronous, active-high; overrides every other input
//   enable      clock enable; low freezes all state except done
//   load_valid  a word is offered on d
//   load_ready  a word can be accepted this cycle (from registered state only)
//   d           word to serialize, sampled only on an accepted load
//   sout        current serial bit (registered)
//   sout_valid  sout carries a data bit (registered)
//   done        one-cycle pulse after the last bit of a word was presented
module word_serializer #(
  parameter int W         = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic         trigger,
  input  logic         reset,
  input  logic         enable,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [W-1:0] d,
  output logic         sout,
  output logic         sout_valid,
  output logic         done
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sout_q, sout_d;
  logic          sout_valid_q, sout_valid_d;
  logic          done_q, done_d;
  logic          accept;
  logic          last_bit;

  // The current bit is the last one of its word when cnt has run out.
  assign last_bit   = (state_q == SHIFT) && (cnt_q == '0);
  assign load_ready = (state_q == IDLE) || last_bit;
  assign accept     = enable && load_valid && load_ready;

  // State register
  always_ff @(posedge trigger) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (enable) begin
      if (accept) begin
        state_d = SHIFT;
      end else if (last_bit) begin
        state_d = IDLE;
      end
    end
  end

  // Datapath / output logic
  always_comb begin
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    done_d       = 1'b0;
    if (enable) begin
      done_d = last_bit;
      if (accept) begin
        // The first bit goes straight to sout; shreg keeps only the rest,
        // so the next bit is always at the same end of shreg.
        sout_d       = (MSB_FIRST != 0) ? d[W-1] : d[0];
        shreg_d      = (MSB_FIRST != 0) ? (d << 1) : (d >> 1);
        cnt_d        = CW'(W - 1);
        sout_valid_d = 1'b1;
      end else if (state_q == SHIFT) begin
        if (cnt_q != '0) begin
          sout_d  = (MSB_FIRST != 0) ? shreg_q[W-1] : shreg_q[0];
          shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
          cnt_d   = cnt_q - 1'b1;
        end else begin
          sout_d       = 1'b0;
          sout_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge trigger) begin
    if (reset) begin
      shreg_q      <= '0;
      cnt_q        <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      done_q       <= done_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: three instances (W=8 MSB-first, W=8 LSB-first,
// W=1) share one stimulus stream; each is compared every cycle against a
// word/bit-position reference model.
module tb_word_serializer;

  logic       trigger = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] d_in = '0;

  logic rdy_m, sout_m, sv_m, done_m;
  logic rdy_l, sout_l, sv_l, done_l;
  logic rdy_1, sout_1, sv_1, done_1;

  int checks = 0;
  int failures = 0;

  always #5 trigger = ~trigger;

  word_serializer #(.W(8), .MSB_FIRST(1)) u_msb (
    .trigger(trigger), .reset(reset), .enable(enable), .load_valid(load_valid),
    .load_ready(rdy_m), .d(d_in), .sout(sout_m), .sout_valid(sv_m), .done(done_m)
  );

  word_serializer #(.W(8), .MSB_FIRST(0)) u_lsb (
    .trigger(trigger), .reset(reset), .enable(enable), .load_valid(load_valid),
    .load_ready(rdy_l), .d(d_in), .sout(sout_l), .sout_valid(sv_l), .done(done_l)
  );

  word_serializer #(.W(1), .MSB_FIRST(1)) u_w1 (
    .trigger(trigger), .reset(reset), .enable(enable), .load_valid(load_valid),
    .load_ready(rdy_1), .d(d_in[0:0]), .sout(sout_1), .sout_valid(sv_1), .done(done_1)
  );

  // Reference model: a word, the index of the bit being shown, and a valid flag.
  int         m_w   [3] = '{8, 8, 1};
  int         m_msb [3] = '{1, 0, 1};
  logic [7:0] m_word[3];
  int         m_pos [3];
  logic       m_val [3];
  logic       m_done[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(int i);
    if (!m_val[i]) return 1'b0;
    return (m_msb[i] != 0) ? m_word[i][m_w[i] - 1 - m_pos[i]] : m_word[i][m_pos[i]];
  endfunction

  function automatic logic exp_ready(int i);
    return !m_val[i] || (m_pos[i] == m_w[i] - 1);
  endfunction

  task automatic model_edge(int i);
    logic last;
    if (reset) begin
      m_val[i] = 1'b0; m_pos[i] = 0; m_done[i] = 1'b0; m_word[i] = '0;
      return;
    end
    if (!enable) begin
      m_done[i] = 1'b0;
      return;
    end
    last = m_val[i] && (m_pos[i] == m_w[i] - 1);
    m_done[i] = last;
    if (load_valid && exp_ready(i)) begin
      m_val[i]  = 1'b1;
      m_pos[i]  = 0;
      m_word[i] = (m_w[i] == 1) ? {7'b0, d_in[0]} : d_in;
    end else if (m_val[i] && !last) begin
      m_pos[i]++;
    end else if (last) begin
      m_val[i] = 1'b0;
      m_pos[i] = 0;
    end
  endtask

  task automatic check_all();
    check("msb_ready", 32'(rdy_m),  32'(exp_ready(0)));
    check("msb_sout",  32'(sout_m), 32'(exp_bit(0)));
    check("msb_valid", 32'(sv_m),   32'(m_val[0]));
    check("msb_done",  32'(done_m), 32'(m_done[0]));
    check("lsb_ready", 32'(rdy_l),  32'(exp_ready(1)));
    check("lsb_sout",  32'(sout_l), 32'(exp_bit(1)));
    check("lsb_valid", 32'(sv_l),   32'(m_val[1]));
    check("lsb_done",  32'(done_l), 32'(m_done[1]));
    check("w1_ready",  32'(rdy_1),  32'(exp_ready(2)));
    check("w1_sout",   32'(sout_1), 32'(exp_bit(2)));
    check("w1_valid",  32'(sv_1),   32'(m_val[2]));
    check("w1_done",   32'(done_1), 32'(m_done[2]));
  endtask

  task automatic step(input logic rst, input logic en, input logic lv, input logic [7:0] dv);
    reset = rst; enable = en; load_valid = lv; d_in = dv;
    @(posedge trigger);
    for (int i = 0; i < 3; i++) model_edge(i);
    @(negedge trigger);
    check_all();
  endtask

  initial begin
    logic [7:0] cap_m, cap_l;
    for (int i = 0; i < 3; i++) begin
      m_word[i] = '0; m_pos[i] = 0; m_val[i] = 1'b0; m_done[i] = 1'b0;
    end

    // Reset held three cycles
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 8'hFF);
    check("reset_ready", 32'(rdy_m), 32'd1);
    check("reset_valid", 32'(sv_m), 32'd0);

    // Single word 0xA5, captured bit by bit in both orders
    step(1'b0, 1'b1, 1'b1, 8'hA5);
    cap_m = {7'b0, sout_m};
    cap_l = {sout_l, 7'b0};
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      cap_m = {cap_m[6:0], sout_m};
      cap_l = {sout_l, cap_l[7:1]};
    end
    check("a5_msb_stream", 32'(cap_m), 32'hA5);
    check("a5_lsb_stream", 32'(cap_l), 32'hA5);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 8'h00);

    // 0x01
    step(1'b0, 1'b1, 1'b1, 8'h01);
    for (int k = 0; k < 9; k++) step(1'b0, 1'b1, 1'b0, 8'h00);

    // Back-to-back 0xFF then 0x00
    step(1'b0, 1'b1, 1'b1, 8'hFF);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    check("b2b_done_at_load", 32'(done_m), 32'd1);
    check("b2b_valid_no_gap", 32'(sv_m), 32'd1);
    for (int k = 0; k < 9; k++) step(1'b0, 1'b1, 1'b0, 8'h00);

    // Enable toggling during 0xC3
    step(1'b0, 1'b1, 1'b1, 8'hC3);
    for (int k = 0; k < 18; k++) step(1'b0, 1'((k % 2) != 0), 1'b0, 8'h00);

    // Reset mid-word, then 0x81
    step(1'b0, 1'b1, 1'b1, 8'hF0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check("abort_no_done", 32'(done_m), 32'd0);
    check("abort_ready", 32'(rdy_m), 32'd1);
    step(1'b0, 1'b1, 1'b1, 8'h81);
    for (int k = 0; k < 9; k++) step(1'b0, 1'b1, 1'b0, 8'h00);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      step(1'($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
